bcd_seg7_scan: RTL and testbench
================================

// Module: bcd_seg7_scan
// PURPOSE
//  Downstream consumer of the 8-bit packed-BCD adder: accepts {carry, tens, units} results via valid/ready,
//  double-buffers them and drives a 3-digit time-multiplexed seven-segment display (hundreds = adder carry).
//  Updates are committed only at frame boundaries, so no frame ever mixes digits from two results.
// PARAMETERS
//  REFRESH_DIV  1000  clk cycles per digit slot (>=2); frame = 3*REFRESH_DIV cycles
// PORTS
//  clk       in   1  system clock, all state on rising edge
//  rst_n     in   1  synchronous, active-low reset
//  in_valid  in   1  in_sum/in_cout valid
//  in_ready  out  1  pending buffer free; transfer when in_valid&&in_ready
//  in_sum    in   8  packed BCD {tens[7:4], units[3:0]} from adder
//  in_cout   in   1  adder carry -> hundreds digit (0/1)
//  seg_n     out  7  segments {g,f,e,d,c,b,a}, active-low
//  an_n      out  3  digit enables {hundreds,tens,units}, active-low, at most one low
//  err       out  1  displayed value contains a non-BCD nibble (>9)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): disp_q=0, pend_q=0, pend_v=0, digit=DIG0, cnt=0, seg_n=7'h7F, an_n=3'b111, err=0.
//  in_ready = !pend_v (combinational from register); 1 from first cycle after reset.
//  Accept: in_valid&&in_ready -> pend_q<={in_cout,in_sum}, pend_v<=1. in_valid while !in_ready is ignored
//   (upstream must hold). No accept in the cycle pend_v is cleared (in_ready still 0 that cycle).
//  Scan counter cnt: 0..REFRESH_DIV-1, wraps; at cnt==REFRESH_DIV-1 digit advances DIG0->DIG1->DIG2->DIG0.
//  Commit: on the edge where digit==DIG2 && cnt==REFRESH_DIV-1 && pend_v -> disp_q<=pend_q, pend_v<=0.
//   First result after reset is visible from the next frame start (worst-case latency 3*REFRESH_DIV+1).
//  Ghost blanking: while cnt==0 all digits off (an_n=111); otherwise active digit's an_n bit low.
//  Digit sources: DIG0=disp_q[3:0], DIG1=disp_q[7:4], DIG2={3'b0,disp_q[8]}.
//  Decode: 0-9 standard patterns; nibble 10-15 -> 'E' (a,d,e,f,g lit).
//  seg_n/an_n/err are registered from current (digit,cnt,disp_q): one-cycle lag vs. scan state.
//  err = 1 iff disp_q[7:4]>9 || disp_q[3:0]>9; updates with commit, cleared only by commit of valid data/reset.
//  Reset mid-frame: immediate return to reset state; pending data discarded; display blank for one cycle.
// CONFIGURATION
//  BCD_LZB_EN defined: leading-zero blanking -- hundreds blanked (seg_n=7F, an_n still scanned) when carry=0;
//   tens blanked when carry=0 && tens==0. Units never blanked. Non-BCD tens never blanked.
//  BCD_LZB_EN undefined: all three digits always shown, e.g. 0x07/c0 displays "007".
// STRUCTURE
//  Package bcd_seg7_pkg: typedef enum {DIG0,DIG1,DIG2} digit_t; SEG_0..SEG_9, SEG_E, SEG_BLANK
//   7-bit active-low constants; localparam helper for cnt width ($clog2(REFRESH_DIV)).
//  Sub-module bcd_to_seg7: combinational 4-bit nibble + blank -> seg_n[6:0]; one instance on muxed digit.
// TESTING (REFRESH_DIV=4 in bench)
//  Reset: hold rst_n=0 3 cycles -> seg_n=7F, an_n=111, err=0, in_ready=1.
//  Load in_sum=0x42,in_cout=1 -> in_ready=0 next cycle; next frame shows an_n=110:SEG_2, 101:SEG_4, 011:SEG_1.
//  Back-to-back: send 0x15 then hold 0x99 valid -> 0x99 stalls until 0x15 commits; then 0x99 accepted, "199"/"099".
//  Invalid: in_sum=0xA3 -> after commit tens shows SEG_E, err=1; then load 0x27 -> err=0.
//  BCD_LZB_EN: in_sum=0x05,c0 -> hundreds and tens blank, units SEG_5; without macro "005".
//  Reset mid-frame with pend_v=1 -> pending dropped, display returns to "000"/blank, in_ready=1.

Source files
------------

// File: rtl/bcd_seg7_pkg.sv
// Shared types and constants for the 3-digit BCD seven-segment scanner.
// Contents: digit slot enum, active-low segment patterns {g,f,e,d,c,b,a},
//           and a helper that sizes the refresh counter from REFRESH_DIV.
package bcd_seg7_pkg;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,    // units
        DIG1 = 2'd1,    // tens
        DIG2 = 2'd2     // hundreds (adder carry)
    } digit_t;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Width of a counter that runs 0..div-1 (div >= 2)
    function automatic int cnt_width(input int div);
        return $clog2(div);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder with blanking.
// Ports: nib (4-bit digit), blank (force all segments off), seg_n (7-bit {g..a}, active-low).
// Nibbles 10..15 decode to 'E' so a corrupt result is visible on the display.
module bcd_to_seg7
    import bcd_seg7_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_E;
        if (blank) begin
            seg_n = SEG_BLANK;
        end else begin
            case (nib)
                4'd0:    seg_n = SEG_0;
                4'd1:    seg_n = SEG_1;
                4'd2:    seg_n = SEG_2;
                4'd3:    seg_n = SEG_3;
                4'd4:    seg_n = SEG_4;
                4'd5:    seg_n = SEG_5;
                4'd6:    seg_n = SEG_6;
                4'd7:    seg_n = SEG_7;
                4'd8:    seg_n = SEG_8;
                4'd9:    seg_n = SEG_9;
                default: seg_n = SEG_E;
            endcase
        end
    end

endmodule

// File: rtl/bcd_seg7_scan.sv
// 3-digit multiplexed seven-segment driver for {carry, tens, units} packed-BCD results.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready/in_sum/in_cout input handshake,
//        seg_n/an_n (active-low segments / digit enables), err (displayed value has a nibble > 9).
// Results are double-buffered (pending -> display) and committed only at frame boundaries,
// so a frame never mixes digits of two results. in_ready is low while a result is pending.
// Optional macro BCD_LZB_EN: leading-zero blanking of the hundreds and tens digits.
module bcd_seg7_scan
    import bcd_seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_sum,
    input  logic       in_cout,
    output logic [6:0] seg_n,
    output logic [2:0] an_n,
    output logic       err
);

    localparam int            CW       = cnt_width(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [8:0]    disp_q;
    logic [8:0]    pend_q;
    logic          pend_v;
    digit_t        digit;
    logic [CW-1:0] cnt;

    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    seg_dec;
    logic [2:0]    an_nxt;
    logic          err_nxt;
    logic          slot_end;
    logic          commit;
    logic          accept;

    assign in_ready = !pend_v;
    assign accept   = in_valid && in_ready;
    assign slot_end = (cnt == CNT_LAST);
    // Last cycle of the hundreds slot is the frame boundary
    assign commit   = slot_end && (digit == DIG2) && pend_v;
    assign err_nxt  = (disp_q[7:4] > 4'd9) || (disp_q[3:0] > 4'd9);

    // Digit source mux and optional leading-zero blanking
    always_comb begin
        nib   = disp_q[3:0];
        blank = 1'b0;
        case (digit)
            DIG1:    nib = disp_q[7:4];
            DIG2:    nib = {3'b000, disp_q[8]};
            default: nib = disp_q[3:0];
        endcase
`ifdef BCD_LZB_EN
        blank = ((digit == DIG2) && !disp_q[8]) ||
                ((digit == DIG1) && !disp_q[8] && (disp_q[7:4] == 4'd0));
`else
        blank = 1'b0;
`endif
    end

    // First cycle of every slot is dark to hide segment ghosting during the switch
    always_comb begin
        an_nxt = 3'b111;
        if (cnt != '0) begin
            case (digit)
                DIG0:    an_nxt = 3'b110;
                DIG1:    an_nxt = 3'b101;
                DIG2:    an_nxt = 3'b011;
                default: an_nxt = 3'b111;
            endcase
        end
    end

    bcd_to_seg7 u_dec (
        .nib   (nib),
        .blank (blank),
        .seg_n (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_q <= '0;
            pend_q <= '0;
            pend_v <= 1'b0;
            digit  <= DIG0;
            cnt    <= '0;
            seg_n  <= SEG_BLANK;
            an_n   <= 3'b111;
            err    <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                case (digit)
                    DIG0:    digit <= DIG1;
                    DIG1:    digit <= DIG2;
                    default: digit <= DIG0;
                endcase
            end else begin
                cnt <= cnt + CW'(1);
            end

            // accept needs pend_v=0 and commit needs pend_v=1: never both
            if (commit) begin
                disp_q <= pend_q;
                pend_v <= 1'b0;
            end
            if (accept) begin
                pend_q <= {in_cout, in_sum};
                pend_v <= 1'b1;
            end

            // Outputs lag the scan state by one cycle
            seg_n <= seg_dec;
            an_n  <= an_nxt;
            err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Testbench for bcd_seg7_scan (REFRESH_DIV=4): driver pushes the expected appearance of
// each accepted result into a queue; a monitor assembles displayed frames and pops/compares.
module tb_bcd_seg7_scan;

    localparam int RD  = 4;
    localparam int LAT = 3 * RD + 2;   // accept edge -> first lit units cycle, worst case

    // Active-high reference patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_ON [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    localparam logic [6:0] SEG_E_ON = 7'h79;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_sum = 8'h00;
    logic       in_cout = 1'b0;
    logic [6:0] seg_n;
    logic [2:0] an_n;
    logic       err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Scoreboard: key = {hundreds seg, tens seg, units seg, err}
    logic [21:0] exp_q [$];
    int          t_q [$];
    logic [21:0] last_key;
    logic [21:0] cur_key;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_seg7_scan #(.REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sum   (in_sum),
        .in_cout  (in_cout),
        .seg_n    (seg_n),
        .an_n     (an_n),
        .err      (err)
    );

    function automatic logic [6:0] exp_seg(input logic [8:0] v, input int idx);
        int d;
        bit blank;
        blank = 1'b0;
        if (idx == 0)      d = int'(v[3:0]);
        else if (idx == 1) d = int'(v[7:4]);
        else               d = int'(v[8]);
`ifdef BCD_LZB_EN
        if (idx == 2 && v[8] == 1'b0) blank = 1'b1;
        if (idx == 1 && v[8] == 1'b0 && v[7:4] == 4'd0) blank = 1'b1;
`endif
        if (blank) return 7'h7F;
        if (d > 9) return ~SEG_E_ON;
        return ~SEG_ON[d];
    endfunction

    function automatic logic [21:0] disp_key(input logic [8:0] v);
        logic e;
        e = (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
        return {exp_seg(v, 2), exp_seg(v, 1), exp_seg(v, 0), e};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic [6:0] fseg [3];
    int         fcnt [3];
    logic [2:0] fv;
    logic       fbad;
    logic       ferr;
    logic       ferr_bad;
    int         fstart;
    int         last_idx;

    task automatic eval_frame();
        logic [21:0] fk;
        fk = {fseg[2], fseg[1], fseg[0], ferr};
        chk("slot_stable", {31'd0, fbad}, 32'd0);
        chk("err_stable", {31'd0, ferr_bad}, 32'd0);
        chk("slot_len", fcnt[0] * 100 + fcnt[1] * 10 + fcnt[2], (RD - 1) * 111);
        checks++;
        if (fk == cur_key) begin
            if (exp_q.size() > 0)
                chk("stale_display", {31'd0, (fstart - t_q[0]) > LAT}, 32'd0);
        end else if (exp_q.size() > 0 && fk == exp_q[0]) begin
            cur_key = exp_q.pop_front();
            chk("latency", {31'd0, (fstart - t_q.pop_front()) <= LAT}, 32'd1);
        end else begin
            errors++;
            $display("FAIL frame: shown %h, expected %h or next %h (cycle %0d)",
                     fk, cur_key, (exp_q.size() > 0) ? exp_q[0] : cur_key, cyc);
        end
    endtask

    always @(negedge clk) begin
        int idx;
        if (!rst_n) begin
            last_idx = -1;
            fv       = 3'b000;
            cur_key  = disp_key(9'd0);
        end else begin
            chk("an_onehot", {31'd0, an_n inside {3'b111, 3'b110, 3'b101, 3'b011}}, 32'd1);
            idx = (an_n == 3'b110) ? 0 : (an_n == 3'b101) ? 1 : (an_n == 3'b011) ? 2 : -1;
            if (idx >= 0) begin
                if (idx == 0 && last_idx != 0) begin
                    if (last_idx == 2 && fv == 3'b111) eval_frame();
                    fv       = 3'b000;
                    fbad     = 1'b0;
                    ferr_bad = 1'b0;
                    ferr     = err;
                    fstart   = cyc;
                    for (int i = 0; i < 3; i++) fcnt[i] = 0;
                end
                if (fv[idx] && fseg[idx] !== seg_n) fbad = 1'b1;
                if (err !== ferr) ferr_bad = 1'b1;
                fseg[idx] = seg_n;
                fv[idx]   = 1'b1;
                fcnt[idx] = fcnt[idx] + 1;
                last_idx  = idx;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [7:0] s, input logic c);
        int w;
        logic [21:0] k;
        w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_sum   = s;
        in_cout  = c;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", {31'd0, in_ready}, 32'd1);
        if (in_ready) begin
            @(posedge clk);
            #1;
            k = disp_key({c, s});
            if (k != last_key) begin
                exp_q.push_back(k);
                t_q.push_back(cyc);
                last_key = k;
            end
            in_valid = 1'b0;
            chk("ready_after_accept", {31'd0, in_ready}, 32'd0);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    initial begin
        int w;
        logic [7:0] s;
        last_key = disp_key(9'd0);

        // Reset held 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_seg", {25'd0, seg_n}, 32'h7F);
        chk("rst_an", {29'd0, an_n}, 32'h7);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed: basic, back-to-back stall, non-BCD, leading zeros
        send(8'h42, 1'b1);
        send(8'h15, 1'b1);
        send(8'h99, 1'b1);
        send(8'h99, 1'b0);
        send(8'hA3, 1'b0);
        send(8'h27, 1'b0);
        send(8'h05, 1'b0);
        send(8'h00, 1'b0);
        send(8'h30, 1'b0);
        send(8'h00, 1'b1);

        // Reset with a result pending: it must be dropped
        send(8'h58, 1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        t_q.delete();
        last_key = disp_key(9'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_seg", {25'd0, seg_n}, 32'h7F);
        chk("midrst_an", {29'd0, an_n}, 32'h7);
        chk("midrst_err", {31'd0, err}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd1);
        repeat (3 * RD * 2) @(posedge clk);

        // Randomized results with random idle gaps
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 15)) @(posedge clk);
            s = 8'($urandom);
            if ($urandom_range(0, 3) != 0)
                s = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            send(s, 1'($urandom_range(0, 1)));
        end

        w = 0;
        while (exp_q.size() > 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        chk("drain", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
